character_motion: RTL and testbench

Per-frame position controller for the player robot. It sits directly downstream of the character/platform collision stage. On each frame tick it waits for the collision flags to settle for the current position, latches them, and applies player input, jump and gravity. It then publishes the new 9-bit character_x_position / character_y_position, which feed back into the collision stage and forward to the sprite renderer.

---
 rtl/character_motion_pkg.sv | 23 ++
 rtl/character_motion.sv | 162 ++++++++++++++++
 tb/tb_character_motion.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/character_motion_pkg.sv
// Shared types and default screen bounds for the player motion controller
// and the collision/render blocks that consume the same coordinates.
package character_motion_pkg;

  typedef logic [8:0] pos_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE,
    COMMIT
  } state_t;

  localparam pos_t       X_START_DEF       = 9'd20;
  localparam pos_t       Y_START_DEF       = 9'd100;
  localparam pos_t       X_MIN_DEF         = 9'd4;
  localparam pos_t       X_MAX_DEF         = 9'd300;
  localparam pos_t       Y_MAX_DEF         = 9'd226;
  localparam pos_t       MOVE_STEP_DEF     = 9'd1;
  localparam logic [5:0] JUMP_FRAMES_DEF   = 6'd24;
  localparam logic [3:0] SETTLE_CYCLES_DEF = 4'd3;

endpackage

// File: rtl/character_motion.sv
// Per-frame position controller: settles collision flags, latches them with the
// controls, applies jump/gravity/horizontal moves and commits the new origin.
module character_motion
  import character_motion_pkg::*;
#(
  parameter pos_t       X_START       = X_START_DEF,
  parameter pos_t       Y_START       = Y_START_DEF,
  parameter pos_t       X_MIN         = X_MIN_DEF,
  parameter pos_t       X_MAX         = X_MAX_DEF,
  parameter pos_t       Y_MAX         = Y_MAX_DEF,
  parameter pos_t       MOVE_STEP     = MOVE_STEP_DEF,
  parameter logic [5:0] JUMP_FRAMES   = JUMP_FRAMES_DEF,
  parameter logic [3:0] SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       jump,
  input  logic [2:0] character_down,
  input  logic [2:0] character_up,
  input  logic [2:0] character_left,
  input  logic [2:0] character_right,
  output logic [8:0] character_x_position,
  output logic [8:0] character_y_position,
  output logic       airborne,
  output logic       step_done
);

  state_t     state_q, state_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [5:0] jump_cnt_q, jump_cnt_d;
  logic       armed_q;
  logic       down_q, up_q, left_q, right_q;
  logic       down_d, up_d, left_d, right_d;
  logic       ml_q, mr_q, jmp_q, ml_d, mr_d, jmp_d;
  pos_t       x_q, x_d, y_q, y_d;
  logic       airborne_q, airborne_d, step_done_q, step_done_d;

  logic [9:0] x_ext, step_ext, x_sum, y_sum;
  logic       jump_start;
  logic [5:0] cnt_eff;

  // armed_q masks a tick that lands in the first cycle after reset release
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      jump_cnt_q   <= '0;
      armed_q      <= 1'b0;
      down_q       <= 1'b0;
      up_q         <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      ml_q         <= 1'b0;
      mr_q         <= 1'b0;
      jmp_q        <= 1'b0;
      x_q          <= X_START;
      y_q          <= Y_START;
      airborne_q   <= 1'b0;
      step_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      jump_cnt_q   <= jump_cnt_d;
      armed_q      <= 1'b1;
      down_q       <= down_d;
      up_q         <= up_d;
      left_q       <= left_d;
      right_q      <= right_d;
      ml_q         <= ml_d;
      mr_q         <= mr_d;
      jmp_q        <= jmp_d;
      x_q          <= x_d;
      y_q          <= y_d;
      airborne_q   <= airborne_d;
      step_done_q  <= step_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_tick && armed_q) state_d = SETTLE;
      SETTLE:  if (settle_cnt_q == '0) state_d = DECIDE;
      DECIDE:  state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign x_ext      = {1'b0, x_q};
  assign step_ext   = {1'b0, MOVE_STEP};
  assign x_sum      = x_ext + step_ext;
  assign y_sum      = {1'b0, y_q} + 10'd1;
  assign jump_start = jmp_q && down_q && !up_q && (jump_cnt_q == '0);
  assign cnt_eff    = jump_start ? JUMP_FRAMES : jump_cnt_q;

  // Position registers load on the DECIDE->COMMIT edge so they change in the
  // same cycle step_done is high.
  always_comb begin
    settle_cnt_d = settle_cnt_q;
    jump_cnt_d   = jump_cnt_q;
    down_d       = down_q;
    up_d         = up_q;
    left_d       = left_q;
    right_d      = right_q;
    ml_d         = ml_q;
    mr_d         = mr_q;
    jmp_d        = jmp_q;
    x_d          = x_q;
    y_d          = y_q;
    airborne_d   = airborne_q;
    step_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick && armed_q) settle_cnt_d = SETTLE_CYCLES;
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          down_d  = |character_down;
          up_d    = |character_up;
          left_d  = |character_left;
          right_d = |character_right;
          ml_d    = move_left;
          mr_d    = move_right;
          jmp_d   = jump;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      DECIDE: begin
        if (cnt_eff != '0 && !up_q) begin
          y_d        = (y_q == '0) ? '0 : y_q - 9'd1;
          jump_cnt_d = cnt_eff - 6'd1;
        end else if (cnt_eff != '0) begin
          jump_cnt_d = '0;
        end else if (!down_q) begin
          y_d = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[8:0];
        end
        if (ml_q && !mr_q && !left_q) begin
          if (x_ext < step_ext || (x_ext - step_ext) < {1'b0, X_MIN})
            x_d = X_MIN;
          else
            x_d = x_q - MOVE_STEP;
        end else if (mr_q && !ml_q && !right_q) begin
          x_d = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[8:0];
        end
        airborne_d  = (jump_cnt_d != '0) || !down_q;
        step_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign character_x_position = x_q;
  assign character_y_position = y_q;
  assign airborne             = airborne_q;
  assign step_done            = step_done_q;

endmodule

// File: tb/tb_character_motion.sv
// Directed bench for character_motion: reset, gravity, jump, ceiling hit,
// horizontal saturation, tick filtering and mid-step reset.
module tb_character_motion;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       move_left = 1'b0, move_right = 1'b0, jump = 1'b0;
  logic [2:0] cdown = '0, cup = '0, cleft = '0, cright = '0;
  logic [8:0] x, y, x2, y2;
  logic       air, sd, air2, sd2;
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  character_motion dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
    .move_left(move_left), .move_right(move_right), .jump(jump),
    .character_down(cdown), .character_up(cup),
    .character_left(cleft), .character_right(cright),
    .character_x_position(x), .character_y_position(y),
    .airborne(air), .step_done(sd)
  );

  character_motion #(.X_START(9'd299), .MOVE_STEP(9'd2)) dut2 (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
    .move_left(move_left), .move_right(move_right), .jump(jump),
    .character_down(cdown), .character_up(cup),
    .character_left(cleft), .character_right(cright),
    .character_x_position(x2), .character_y_position(y2),
    .airborne(air2), .step_done(sd2)
  );

  task automatic apply_reset();
    resetn = 1'b0; frame_tick = 1'b0;
    move_left = 1'b0; move_right = 1'b0; jump = 1'b0;
    cdown = '0; cup = '0; cleft = '0; cright = '0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // Pulses frame_tick and measures cycles to step_done (bounded at 20).
  task automatic do_frame(output int lat, output logic after);
    bit seen;
    @(negedge clock); frame_tick = 1'b1; seen = 1'b0;
    @(negedge clock); frame_tick = 1'b0; lat = 1;
    while (!seen && lat < 20) begin
      if (sd === 1'b1) seen = 1'b1;
      else begin @(negedge clock); lat++; end
    end
    @(negedge clock); after = sd;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (x !== 9'd20) begin errors++; $display("FAIL reset_x got %0d want 20", x); end
    checks++; if (y !== 9'd100) begin errors++; $display("FAIL reset_y got %0d want 100", y); end
    checks++; if (air !== 1'b0) begin errors++; $display("FAIL reset_air got %b want 0", air); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL reset_sd got %b want 0", sd); end
  endtask

  task automatic test_fall();
    int lat; logic after; int bad = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_frame(lat, after);
      if (lat != 6 || after !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fall_latency bad frames %0d want 0 (last lat %0d want 6)", bad, lat); end
    checks++; if (y !== 9'd105) begin errors++; $display("FAIL fall_y got %0d want 105", y); end
    checks++; if (air !== 1'b1) begin errors++; $display("FAIL fall_air got %b want 1", air); end
  endtask

  task automatic test_jump();
    int lat; logic after;
    apply_reset();
    cdown = 3'b010; jump = 1'b1;
    do_frame(lat, after);
    checks++; if (y !== 9'd99) begin errors++; $display("FAIL jump_first_y got %0d want 99", y); end
    checks++; if (air !== 1'b1) begin errors++; $display("FAIL jump_first_air got %b want 1", air); end
    jump = 1'b0;
    for (int i = 0; i < 23; i++) do_frame(lat, after);
    checks++; if (y !== 9'd76) begin errors++; $display("FAIL jump_peak_y got %0d want 76", y); end
    checks++; if (air !== 1'b0) begin errors++; $display("FAIL jump_peak_air got %b want 0", air); end
    cdown = '0;
    do_frame(lat, after);
    checks++; if (y !== 9'd77) begin errors++; $display("FAIL jump_fall_y got %0d want 77", y); end
    checks++; if (air !== 1'b1) begin errors++; $display("FAIL jump_fall_air got %b want 1", air); end
  endtask

  task automatic test_ceiling();
    int lat; logic after;
    apply_reset();
    cdown = 3'b100; jump = 1'b1;
    do_frame(lat, after);
    jump = 1'b0;
    for (int i = 0; i < 4; i++) do_frame(lat, after);
    checks++; if (y !== 9'd95) begin errors++; $display("FAIL ceil_pre_y got %0d want 95", y); end
    cup = 3'b001;
    do_frame(lat, after);
    checks++; if (y !== 9'd95) begin errors++; $display("FAIL ceil_hit_y got %0d want 95", y); end
    cup = '0; cdown = '0;
    do_frame(lat, after);
    checks++; if (y !== 9'd96) begin errors++; $display("FAIL ceil_fall_y got %0d want 96", y); end
  endtask

  task automatic test_left();
    int lat; logic after;
    apply_reset();
    cdown = 3'b001; move_left = 1'b1;
    do_frame(lat, after);
    checks++; if (x !== 9'd19) begin errors++; $display("FAIL left_step_x got %0d want 19", x); end
    for (int i = 0; i < 16; i++) do_frame(lat, after);
    checks++; if (x !== 9'd4) begin errors++; $display("FAIL left_sat_x got %0d want 4", x); end
    move_left = 1'b0; move_right = 1'b1; cright = 3'b010;
    do_frame(lat, after);
    checks++; if (x !== 9'd4) begin errors++; $display("FAIL right_blocked_x got %0d want 4", x); end
    checks++; if (y !== 9'd100) begin errors++; $display("FAIL left_y got %0d want 100", y); end
  endtask

  task automatic test_right_and_both();
    int lat; logic after;
    apply_reset();
    cdown = 3'b001; move_right = 1'b1;
    do_frame(lat, after);
    checks++; if (x !== 9'd21) begin errors++; $display("FAIL right_x got %0d want 21", x); end
    checks++; if (x2 !== 9'd300) begin errors++; $display("FAIL right_sat_x2 got %0d want 300", x2); end
    do_frame(lat, after);
    checks++; if (x2 !== 9'd300) begin errors++; $display("FAIL right_hold_x2 got %0d want 300", x2); end
    move_left = 1'b1;
    do_frame(lat, after);
    checks++; if (x !== 9'd22) begin errors++; $display("FAIL both_x got %0d want 22", x); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    apply_reset();
    cdown = 3'b001;
    @(negedge clock); frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sd === 1'b1) pulses++;
      @(negedge clock);
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL double_tick pulses got %0d want 1", pulses); end
  endtask

  task automatic test_reset_mid_step();
    int lat; logic after; int pulses = 0;
    apply_reset();
    move_right = 1'b1;
    do_frame(lat, after);
    @(negedge clock); frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0;
    @(negedge clock); resetn = 1'b0;
    #1;
    checks++; if (x !== 9'd20) begin errors++; $display("FAIL midrst_x got %0d want 20", x); end
    checks++; if (y !== 9'd100) begin errors++; $display("FAIL midrst_y got %0d want 100", y); end
    @(negedge clock); resetn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (sd === 1'b1) pulses++;
      @(negedge clock);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_tick_at_release();
    int pulses = 0;
    resetn = 1'b0; frame_tick = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1; frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (sd === 1'b1) pulses++;
      @(negedge clock);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL release_tick pulses got %0d want 0", pulses); end
  endtask

  task automatic test_floor();
    int lat; logic after;
    apply_reset();
    for (int i = 0; i < 130; i++) do_frame(lat, after);
    checks++; if (y !== 9'd226) begin errors++; $display("FAIL floor_y got %0d want 226", y); end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_jump();
    test_ceiling();
    test_left();
    test_right_and_both();
    test_back_to_back();
    test_reset_mid_step();
    test_tick_at_release();
    test_floor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
